// File: rtl/cache_2way_wt.sv
// cache_2way_wt: 2-way set-associative, write-through, no-write-allocate
// byte cache with per-set LRU, write handshake and invalidate-all sweep.
module cache_2way_wt #(
    parameter int ADDR_W   = 13,
    parameter int INDEX_W  = 6,
    parameter int OFFSET_W = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [ADDR_W-1:0]         addr_from_cpu,
    input  logic                      rreq_from_cpu,
    input  logic                      wreq_from_cpu,
    input  logic [7:0]                wdata_from_cpu,
    input  logic                      inv_from_cpu,
    input  logic [(8<<OFFSET_W)-1:0]  rdata_from_mem,
    input  logic                      rvalid_from_mem,
    input  logic                      wdone_from_mem,
    output logic [7:0]                rdata_to_cpu,
    output logic                      ack_to_cpu,
    output logic                      rreq_to_mem,
    output logic [ADDR_W-1:0]         raddr_to_mem,
    output logic                      wreq_to_mem,
    output logic [ADDR_W-1:0]         waddr_to_mem,
    output logic [7:0]                wdata_to_mem
);

    localparam int LINE_W = 8 << OFFSET_W;
    localparam int TAG_W  = ADDR_W - INDEX_W - OFFSET_W;
    localparam int SETS   = 1 << INDEX_W;
    localparam int BSEL_W = OFFSET_W + 3;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] LOOKUP    = 3'd1;
    localparam logic [2:0] REFILL    = 3'd2;
    localparam logic [2:0] WRITE_MEM = 3'd3;
    localparam logic [2:0] FLUSH     = 3'd4;

    logic [2:0]         state;
    logic [ADDR_W-1:0]  a_q;
    logic [7:0]         wd_q;
    logic               wr_q;
    logic               refilled;
    logic [INDEX_W-1:0] fcnt;
    logic [SETS-1:0]    valid0;
    logic [SETS-1:0]    valid1;
    logic [SETS-1:0]    lru;

    logic [TAG_W-1:0]  tag_mem0  [SETS];
    logic [TAG_W-1:0]  tag_mem1  [SETS];
    logic [LINE_W-1:0] line_mem0 [SETS];
    logic [LINE_W-1:0] line_mem1 [SETS];

    logic [TAG_W-1:0]   tag0_q;
    logic [TAG_W-1:0]   tag1_q;
    logic [LINE_W-1:0]  line0_q;
    logic [LINE_W-1:0]  line1_q;
    logic [LINE_W-1:0]  line_sel;

    logic [TAG_W-1:0]   l_tag;
    logic [INDEX_W-1:0] l_idx;
    logic [INDEX_W-1:0] rd_idx;
    logic [BSEL_W-1:0]  bsel;
    logic               hit0;
    logic               hit1;
    logic               hit;
    logic               rd_hit;
    logic               whit;
    logic               fill;
    logic               victim;

    assign l_tag  = a_q[ADDR_W-1 -: TAG_W];
    assign l_idx  = a_q[OFFSET_W +: INDEX_W];
    assign bsel   = {a_q[OFFSET_W-1:0], 3'b000};
    // Arrays are read with the CPU index in IDLE so LOOKUP sees data at once
    assign rd_idx = (state == IDLE) ?
                    addr_from_cpu[OFFSET_W +: INDEX_W] : l_idx;

    assign hit0   = valid0[l_idx] && (tag0_q == l_tag);
    assign hit1   = valid1[l_idx] && (tag1_q == l_tag);
    assign hit    = hit0 | hit1;
    assign rd_hit = (state == LOOKUP) && !wr_q && hit;
    assign whit   = (state == LOOKUP) && wr_q && hit;
    assign fill   = (state == REFILL) && !refilled && rvalid_from_mem;
    assign victim = !valid0[l_idx] ? 1'b0 :
                    (!valid1[l_idx] ? 1'b1 : lru[l_idx]);
    assign line_sel = hit1 ? line1_q : line0_q;

    always_ff @(posedge clk) begin
        if (fill && !victim) begin
            tag_mem0[l_idx]  <= l_tag;
            line_mem0[l_idx] <= rdata_from_mem;
        end else if (whit && hit0) begin
            line_mem0[l_idx][bsel +: 8] <= wd_q;
        end
        tag0_q  <= tag_mem0[rd_idx];
        line0_q <= line_mem0[rd_idx];
    end

    always_ff @(posedge clk) begin
        if (fill && victim) begin
            tag_mem1[l_idx]  <= l_tag;
            line_mem1[l_idx] <= rdata_from_mem;
        end else if (whit && hit1) begin
            line_mem1[l_idx][bsel +: 8] <= wd_q;
        end
        tag1_q  <= tag_mem1[rd_idx];
        line1_q <= line_mem1[rd_idx];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            a_q      <= '0;
            wd_q     <= '0;
            wr_q     <= 1'b0;
            refilled <= 1'b0;
            fcnt     <= '0;
            valid0   <= '0;
            valid1   <= '0;
            lru      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    fcnt <= '0;
                    if (inv_from_cpu) begin
                        state <= FLUSH;
                    end else if (rreq_from_cpu || wreq_from_cpu) begin
                        a_q   <= addr_from_cpu;
                        wd_q  <= wdata_from_cpu;
                        wr_q  <= wreq_from_cpu && !rreq_from_cpu;
                        state <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit)
                        lru[l_idx] <= hit0;
                    if (wr_q) begin
                        state <= WRITE_MEM;
                    end else if (hit) begin
                        state <= IDLE;
                    end else begin
                        refilled <= 1'b0;
                        state    <= REFILL;
                    end
                end
                REFILL: begin
                    // One settle cycle lets the new line reach the read ports
                    if (refilled) begin
                        state <= LOOKUP;
                    end else if (rvalid_from_mem) begin
                        refilled <= 1'b1;
                        if (victim)
                            valid1[l_idx] <= 1'b1;
                        else
                            valid0[l_idx] <= 1'b1;
                        lru[l_idx] <= ~victim;
                    end
                end
                WRITE_MEM: begin
                    if (wdone_from_mem)
                        state <= IDLE;
                end
                FLUSH: begin
                    valid0[fcnt] <= 1'b0;
                    valid1[fcnt] <= 1'b0;
                    lru[fcnt]    <= 1'b0;
                    fcnt         <= fcnt + 1'b1;
                    if (&fcnt)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ack_to_cpu   = rd_hit ||
                          ((state == WRITE_MEM) && wdone_from_mem) ||
                          ((state == FLUSH) && (&fcnt));
    assign rdata_to_cpu = rd_hit ? line_sel[bsel +: 8] : 8'h00;
    assign rreq_to_mem  = (state == REFILL) && !refilled;
    assign raddr_to_mem = rreq_to_mem ?
                          {a_q[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}} : '0;
    assign wreq_to_mem  = (state == WRITE_MEM);
    assign waddr_to_mem = wreq_to_mem ? a_q : '0;
    assign wdata_to_mem = wreq_to_mem ? wd_q : 8'h00;

endmodule

// File: tb/tb_cache_2way_wt.sv
// tb_cache_2way_wt: randomized self-checking bench for cache_2way_wt
// against a tag-recency model backed by a byte memory.
module tb_cache_2way_wt;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [12:0] addr;
    logic        rreq;
    logic        wreq;
    logic [7:0]  wdata;
    logic        inv;
    logic [31:0] mdata;
    logic        rvalid;
    logic        wdone;
    logic [7:0]  rdata_to_cpu;
    logic        ack_to_cpu;
    logic        rreq_to_mem;
    logic [12:0] raddr_to_mem;
    logic        wreq_to_mem;
    logic [12:0] waddr_to_mem;
    logic [7:0]  wdata_to_mem;

    always #5 clk = ~clk;

    cache_2way_wt dut (
        .clk             (clk),
        .reset           (reset),
        .addr_from_cpu   (addr),
        .rreq_from_cpu   (rreq),
        .wreq_from_cpu   (wreq),
        .wdata_from_cpu  (wdata),
        .inv_from_cpu    (inv),
        .rdata_from_mem  (mdata),
        .rvalid_from_mem (rvalid),
        .wdone_from_mem  (wdone),
        .rdata_to_cpu    (rdata_to_cpu),
        .ack_to_cpu      (ack_to_cpu),
        .rreq_to_mem     (rreq_to_mem),
        .raddr_to_mem    (raddr_to_mem),
        .wreq_to_mem     (wreq_to_mem),
        .waddr_to_mem    (waddr_to_mem),
        .wdata_to_mem    (wdata_to_mem)
    );

    int n_chk = 0;
    int n_fail = 0;

    logic        exp_ack;
    logic [7:0]  exp_rdata;
    logic        exp_rreq;
    logic [12:0] exp_raddr;
    logic        exp_wreq;
    logic [12:0] exp_waddr;
    logic [7:0]  exp_wdata;

    // Backing memory and per-set tag list, most recent first
    logic [7:0] bmem [8192];
    logic [4:0] mt [64][2];
    int         mn [64];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("ack_to_cpu",   32'(ack_to_cpu),   32'(exp_ack));
        chk("rdata_to_cpu", 32'(rdata_to_cpu), 32'(exp_rdata));
        chk("rreq_to_mem",  32'(rreq_to_mem),  32'(exp_rreq));
        chk("raddr_to_mem", 32'(raddr_to_mem), 32'(exp_raddr));
        chk("wreq_to_mem",  32'(wreq_to_mem),  32'(exp_wreq));
        chk("waddr_to_mem", 32'(waddr_to_mem), 32'(exp_waddr));
        chk("wdata_to_mem", 32'(wdata_to_mem), 32'(exp_wdata));
    end

    function automatic bit m_hit(input logic [5:0] s, input logic [4:0] t);
        for (int i = 0; i < mn[s]; i++)
            if (mt[s][i] == t) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void m_use(input logic [5:0] s, input logic [4:0] t);
        if (mn[s] > 0 && mt[s][0] == t) return;
        if (mn[s] == 2 && mt[s][1] == t) begin
            mt[s][1] = mt[s][0];
            mt[s][0] = t;
            return;
        end
        mt[s][1] = mt[s][0];
        mt[s][0] = t;
        if (mn[s] < 2) mn[s]++;
    endfunction

    function automatic void m_clear();
        for (int i = 0; i < 64; i++) mn[i] = 0;
    endfunction

    function automatic logic [31:0] line_of(input logic [12:0] la);
        return {bmem[la + 13'd3], bmem[la + 13'd2],
                bmem[la + 13'd1], bmem[la]};
    endfunction

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_exp();
        exp_ack = 0; exp_rdata = 0; exp_rreq = 0; exp_raddr = 0;
        exp_wreq = 0; exp_waddr = 0; exp_wdata = 0;
    endtask

    task automatic idle_in();
        rreq = 0; wreq = 0; inv = 0; rvalid = 0; wdone = 0;
    endtask

    task automatic do_idle();
        next(); idle_in(); clr_exp();
    endtask

    task automatic do_read(input logic [12:0] a, input bit both,
                           input int d, input bit scr,
                           output logic [7:0] got, output bit missed);
        logic [5:0] s;
        logic [4:0] t;
        bit h;
        s = a[7:2];
        t = a[12:8];
        h = m_hit(s, t);
        next(); idle_in(); clr_exp();
        addr = a; rreq = 1; wreq = both; wdata = 8'($urandom);
        rvalid = ($urandom_range(0, 3) == 0); mdata = $urandom;
        next(); clr_exp();
        rvalid = ($urandom_range(0, 3) == 0);
        wdone = ($urandom_range(0, 3) == 0);
        mdata = $urandom;
        if (scr) begin addr = 13'($urandom); wdata = 8'($urandom); end
        missed = 0;
        if (!h) begin
            missed = 1;
            for (int i = 0; i <= d; i++) begin
                next(); clr_exp();
                exp_rreq = 1; exp_raddr = {a[12:2], 2'b00};
                wdone = ($urandom_range(0, 3) == 0);
                rvalid = (i == d);
                mdata = (i == d) ? line_of({a[12:2], 2'b00}) : $urandom;
            end
            next(); clr_exp();
            rvalid = ($urandom_range(0, 1) == 0); wdone = 0;
            mdata = $urandom;
            next(); clr_exp();
            rvalid = 0; wdone = 0;
        end
        exp_ack = 1;
        exp_rdata = bmem[a];
        m_use(s, t);
        @(negedge clk);
        got = rdata_to_cpu;
    endtask

    task automatic do_write(input logic [12:0] a, input logic [7:0] v,
                            input int d, input bit scr, output int nw);
        logic [5:0] s;
        logic [4:0] t;
        bit h;
        s = a[7:2];
        t = a[12:8];
        h = m_hit(s, t);
        next(); idle_in(); clr_exp();
        addr = a; wreq = 1; wdata = v;
        rvalid = ($urandom_range(0, 3) == 0);
        wdone = ($urandom_range(0, 3) == 0);
        mdata = $urandom;
        next(); clr_exp();
        rvalid = ($urandom_range(0, 3) == 0);
        wdone = ($urandom_range(0, 3) == 0);
        if (scr) begin addr = 13'($urandom); wdata = 8'($urandom); end
        nw = 0;
        for (int i = 0; i <= d; i++) begin
            next(); clr_exp();
            rvalid = ($urandom_range(0, 3) == 0);
            wdone = (i == d);
            exp_wreq = 1; exp_waddr = a; exp_wdata = v;
            exp_ack = (i == d);
            @(negedge clk);
            if (wreq_to_mem) nw++;
        end
        bmem[a] = v;
        if (h) m_use(s, t);
    endtask

    task automatic do_flush(output int ack_cyc);
        next(); idle_in(); clr_exp();
        inv = 1;
        ack_cyc = -1;
        for (int c = 1; c <= 64; c++) begin
            next(); clr_exp();
            rvalid = ($urandom_range(0, 3) == 0);
            wdone = ($urandom_range(0, 3) == 0);
            exp_ack = (c == 64);
            @(negedge clk);
            if (ack_to_cpu && ack_cyc < 0) ack_cyc = c;
        end
        m_clear();
    endtask

    initial begin
        logic [7:0] got;
        bit         miss;
        int         nw;
        int         fc;
        int         op;
        int         d;
        logic [4:0] rt;
        logic [5:0] ri;
        logic [1:0] ro;
        logic [12:0] ra;

        idle_in(); addr = 0; wdata = 0; mdata = 0;
        clr_exp(); m_clear();
        for (int i = 0; i < 8192; i++) bmem[i] = 8'($urandom);
        bmem[13'h0104] = 8'hAA; bmem[13'h0105] = 8'hBB;
        bmem[13'h0106] = 8'hCC; bmem[13'h0107] = 8'hDD;

        repeat (3) @(posedge clk);
        #1 reset = 1;

        do_read(13'h0104, 0, 3, 0, got, miss);
        chk("t1_miss", 32'(miss), 32'd1);
        chk("t1_rdata", 32'(got), 32'hAA);
        do_read(13'h0106, 0, 0, 0, got, miss);
        chk("t1_hit", 32'(miss), 32'd0);
        chk("t1_rdata2", 32'(got), 32'hCC);

        do_read(13'h0204, 0, 1, 0, got, miss);
        chk("t2_miss_0204", 32'(miss), 32'd1);
        do_read(13'h0104, 0, 0, 0, got, miss);
        chk("t2_hit_0104", 32'(miss), 32'd0);
        do_read(13'h0304, 0, 2, 0, got, miss);
        chk("t2_miss_0304", 32'(miss), 32'd1);
        do_read(13'h0104, 0, 0, 0, got, miss);
        chk("t2_hit_0104b", 32'(miss), 32'd0);
        do_read(13'h0204, 0, 0, 0, got, miss);
        chk("t2_evicted_0204", 32'(miss), 32'd1);

        do_write(13'h0105, 8'h5A, 2, 0, nw);
        chk("t3_wreq_cycles", 32'(nw), 32'd3);
        do_read(13'h0105, 0, 0, 0, got, miss);
        chk("t3_hit", 32'(miss), 32'd0);
        chk("t3_rdata", 32'(got), 32'h5A);

        do_write(13'h1F00, 8'h11, 0, 0, nw);
        chk("t4_wreq_cycles", 32'(nw), 32'd1);
        do_read(13'h1F00, 0, 1, 0, got, miss);
        chk("t4_no_alloc", 32'(miss), 32'd1);
        chk("t4_rdata", 32'(got), 32'h11);

        do_read(13'h0008, 0, 0, 0, got, miss);
        do_read(13'h0A10, 0, 1, 0, got, miss);
        do_flush(fc);
        chk("t5_flush_ack_cycle", 32'(fc), 32'd64);
        do_read(13'h0104, 0, 0, 0, got, miss);
        chk("t5_miss_after_inv", 32'(miss), 32'd1);

        next(); idle_in(); clr_exp();
        addr = 13'h0304; rreq = 1;
        next(); clr_exp();
        next(); clr_exp(); exp_rreq = 1; exp_raddr = 13'h0304;
        next(); clr_exp(); exp_rreq = 1; exp_raddr = 13'h0304;
        next(); reset = 0; rreq = 0; clr_exp();
        @(negedge clk);
        chk("t6_rreq_in_reset", 32'(rreq_to_mem), 32'd0);
        chk("t6_ack_in_reset", 32'(ack_to_cpu), 32'd0);
        next(); next();
        reset = 1;
        m_clear();
        do_read(13'h0104, 0, 0, 0, got, miss);
        chk("t6_miss_after_reset", 32'(miss), 32'd1);
        chk("t6_rdata", 32'(got), 32'hAA);

        for (int k = 0; k < 300; k++) begin
            op = $urandom_range(0, 99);
            d  = $urandom_range(0, 3);
            rt = 5'($urandom_range(0, 3));
            ri = 6'($urandom_range(0, 3));
            ro = 2'($urandom);
            ra = {rt, ri, ro};
            if (op < 2)
                do_flush(fc);
            else if (op < 50)
                do_read(ra, 0, d, 1, got, miss);
            else if (op < 55)
                do_read(ra, 1, d, 1, got, miss);
            else if (op < 92)
                do_write(ra, 8'($urandom), d, 1, nw);
            else
                do_idle();
        end

        do_idle();
        do_idle();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
